onehot_rr_arbiter: RTL

- Upstream stage for encoder_4to2.
- Captures single-cycle request pulses from 4 sources into a pending register.
- Issues them one at a time as a registered one-hot grant using round-robin priority, under a valid/ready handshake.
- gnt drives the encoder's D input directly. It is guaranteed one-hot when valid and all-zero otherwise, so the encoder never sees a multi-hot input.

---
 rtl/onehot_rr_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: captures request pulses into pending bits and
// issues them one at a time as a registered one-hot grant.
module onehot_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               gnt_ready,
  input  logic               clr_overrun,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] pending,
  output logic               overrun
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state, state_n;
  logic [LW-1:0]      ptr, ptr_n, sel_ptr, gidx;
  logic [NUM_REQ-1:0] sel_oh, clr_mask;
  logic [NUM_REQ-1:0] gnt_n, pending_n;
  logic               hs, load, found, ovr_set;

  assign gnt_valid = (state == GRANT);
  assign hs        = (state == GRANT) && gnt_ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gidx = LW'(i);
    end
  end

  // On a completed handshake the next pick already uses the advanced ptr
  assign sel_ptr = hs ? gidx + 1'b1 : ptr;

  always_comb begin
    logic [LW-1:0] idx;
    sel_oh = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = sel_ptr + LW'(k);
      if (!found && pending[idx]) begin
        found       = 1'b1;
        sel_oh[idx] = 1'b1;
      end
    end
  end

  assign load     = ((state == IDLE) || hs) && (pending != '0);
  assign clr_mask = load ? sel_oh : '0;
  assign ptr_n    = sel_ptr;
  assign ovr_set  = |(req_in & pending & ~clr_mask);

  // Set from req_in wins over the clear of the line being loaded
  assign pending_n = (pending & ~clr_mask) | req_in;

  always_comb begin
    gnt_n   = gnt;
    state_n = state;
    if (load) begin
      gnt_n   = sel_oh;
      state_n = GRANT;
    end else if (hs) begin
      gnt_n   = '0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      pending <= '0;
      ptr     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      pending <= pending_n;
      ptr     <= ptr_n;
      overrun <= ovr_set | (overrun & ~clr_overrun);
    end
  end

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(gnt));

  a_gnt_valid: assert property (
    @(posedge clk) disable iff (rst) ((gnt != '0) == gnt_valid));

endmodule
